filter_gauss_5x5: RTL and testbench
===================================

// Module: filter_gauss_5x5
// PURPOSE
//  Consumes the 5x5 pixel window and de/hs/vs from filter_core_5x5; outputs one Gaussian-smoothed pixel per window.
//  Fixed separable binomial kernel [1 4 6 4 1] x [1 4 6 4 1] (sum 256), fully pipelined, one result per clock.
//  Sits directly downstream of the window generator in the video filter chain; sync signals are delay-matched.
// PARAMETERS
//  DATA_WIDTH  12  pixel width; must equal the upstream window's DATA_WIDTH
// PORTS
//  clk     in   1               single clock, all logic on posedge
//  rst     in   1               synchronous, active-high reset
//  bypass  in   1               1: do_o = centre pixel x12 (delayed), 0: filtered result
//  win_i   in   25*DATA_WIDTH   packed window; xNN at bits [NN*DATA_WIDTH +: DATA_WIDTH], x00 top-left, x12 centre, x24 bottom-right
//  de_i    in   1               window valid (upstream de_o)
//  hs_i    in   1               upstream hs_o
//  vs_i    in   1               upstream vs_o
//  do_o    out  DATA_WIDTH      filtered pixel
//  de_o    out  1               de_i delayed by LAT
//  hs_o    out  1               hs_i delayed by LAT
//  vs_o    out  1               vs_i delayed by LAT
// BEHAVIOUR
//  - Pipeline is free-running (advances every clk, no enable); works with any upstream DE_I_PERIOD because
//    upstream holds the window between de pulses; do_o is sampled only where de_o=1.
//  - LAT = 5 clocks from win_i/de_i to do_o/de_o. de/hs/vs use a 5-deep shift register each.
//  - S1 per row r (5 rows): a=x[r,0]+x[r,4], b=x[r,1]+x[r,3], c=x[r,2]; widths DW+1.
//  - S2 row sum rs_r = a + (b<<2) + (c<<2) + (c<<1); width DW+4 (max 16*(2^DW-1)).
//  - S3 columns: A=rs0+rs4, B=rs1+rs3, C=rs2; width DW+5.
//  - S4 total T = A + (B<<2) + (C<<2) + (C<<1); width DW+8 (max 256*(2^DW-1)); no overflow at any stage.
//  - S5 normalise: do_o = T[DW+7:8] (see CONFIGURATION); result never exceeds 2^DW-1, no saturation needed.
//  - Bypass path: x12 delayed 5 clocks in parallel; bypass is sampled at S5 only, so a change takes effect on
//    the next do_o with no pipeline flush; de/hs/vs delays are identical in both modes.
//  - Reset: all pipeline regs, delay lines and outputs (do_o, de_o, hs_o, vs_o) = 0 one clk after rst=1.
//    Reset mid-frame: outputs stay 0 for rst duration; first valid de_o appears LAT clks after de_i resumes.
//  - Boundaries: all-zero window -> 0; all-max window -> 2^DW-1 exactly; X/Z on win_i must not reach de/hs/vs.
// CONFIGURATION
//  FILTER_GAUSS_5X5_ROUND_EN
//   defined:   S5 computes (T + 128) >> 8 (round half up); T+128 uses DW+9 bits, upper result still <= 2^DW-1.
//   undefined: S5 computes T >> 8 (truncate). Latency, ports and bypass identical either way.
// STRUCTURE
//  - Shared include filter_defs.vh: kernel taps K0=1,K1=4,K2=6, KSUM_LOG2=8, GAUSS5_LAT=5 (used by upstream
//    integrators for sync alignment).
//  - Sub-module filter_binom5_sum #(IW): 5 inputs -> registered 1-4-6-4-1 weighted sum, 2 register stages
//    (pair-add, then shift-add); output width IW+4. Instantiated 5x for rows (S1-S2), 1x for column (S3-S4).
//  - Top holds unpack of win_i, S5 normalise/round, bypass delay line and mux, sync delay lines.
// TESTING (DATA_WIDTH=12 unless noted)
//  1 Flat window, all xNN=100, de_i=1 -> do_o=100 with de_o=1 exactly 5 clks after de_i.
//  2 Impulse x12=256, others 0 -> do_o=36; impulse x00=256 -> do_o=1; x06=256 -> do_o=16.
//  3 Only x00=255: ROUND_EN off -> do_o=0; ROUND_EN on -> do_o=1. x00=127 with ROUND_EN -> 0.
//  4 All xNN=4095 -> do_o=4095 in both builds (no wrap); all 0 -> 0.
//  5 bypass=1, x12=0xABC, others random -> do_o=0xABC after 5 clks; toggle bypass mid-line -> next do_o switches, de_o cadence unchanged.
//  6 Stream frame from filter_core_5x5 (DE_I_PERIOD=0 and 2), assert rst for 3 clks mid-line -> outputs 0 during rst,
//    de/hs/vs resume aligned; full-frame compare vs integer reference model.

Source files
------------

// File: rtl/filter_gauss_5x5_pkg.sv
// Shared constants and types for the 5x5 binomial Gaussian smoother.
package filter_gauss_5x5_pkg;

    // Kernel [1 4 6 4 1] x [1 4 6 4 1] sums to 256.
    localparam int unsigned KSUM_LOG2  = 8;
    localparam int unsigned GAUSS5_LAT = 5;
    localparam int unsigned ROUND_BIAS = 1 << (KSUM_LOG2 - 1);

    // Video sync bundle carried alongside the pixel pipeline.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

endpackage

// File: rtl/filter_binom5_sum.sv
// Registered 1-4-6-4-1 weighted sum of five inputs: pair-add stage, then shift-add stage.
module filter_binom5_sum
    import filter_gauss_5x5_pkg::*;
#(
    parameter int unsigned IW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5*IW-1:0] x,
    output logic [IW+3:0]   sum
);

    logic [IW:0]   a_q;
    logic [IW:0]   b_q;
    logic [IW:0]   c_q;
    logic [IW+3:0] sum_q;

    // Stage 1: fold the symmetric taps into pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= {1'b0, x[0*IW +: IW]} + {1'b0, x[4*IW +: IW]};
            b_q <= {1'b0, x[1*IW +: IW]} + {1'b0, x[3*IW +: IW]};
            c_q <= {1'b0, x[2*IW +: IW]};
        end
    end

    // Stage 2: a + 4b + 6c; max 16*(2^IW-1) fits IW+4 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= {3'b000, a_q} + {1'b0, b_q, 2'b00} + {1'b0, c_q, 2'b00} + {2'b00, c_q, 1'b0};
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/filter_gauss_5x5.sv
// 5x5 Gaussian smoother, fixed latency of 5 clocks with delay-matched de/hs/vs.
// Optional build macro FILTER_GAUSS_5X5_ROUND_EN: round half up instead of truncating.
module filter_gauss_5x5
    import filter_gauss_5x5_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bypass,
    input  logic [25*DATA_WIDTH-1:0] win_i,
    input  logic                     de_i,
    input  logic                     hs_i,
    input  logic                     vs_i,
    output logic [DATA_WIDTH-1:0]    do_o,
    output logic                     de_o,
    output logic                     hs_o,
    output logic                     vs_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned RW = DW + 4;
    localparam int unsigned TW = DW + 8;

    logic [5*RW-1:0] row_sums;
    logic [TW-1:0]   total;
    logic [DW-1:0]   norm;
    logic [DW-1:0]   ctr_q [GAUSS5_LAT-1];
    sync_t           sync_q [GAUSS5_LAT];
    logic [DW-1:0]   do_q;

    // S1-S2: one weighted sum per window row; row r is pixels x[5r .. 5r+4].
    for (genvar r = 0; r < 5; r++) begin : g_row
        filter_binom5_sum #(
            .IW (DW)
        ) u_row (
            .clk (clk),
            .rst (rst),
            .x   (win_i[r*5*DW +: 5*DW]),
            .sum (row_sums[r*RW +: RW])
        );
    end

    // S3-S4: weighted sum down the column of row sums.
    filter_binom5_sum #(
        .IW (RW)
    ) u_col (
        .clk (clk),
        .rst (rst),
        .x   (row_sums),
        .sum (total)
    );

`ifdef FILTER_GAUSS_5X5_ROUND_EN
    logic [TW:0] total_rnd;

    // Round half up; the extra bit keeps the bias add from wrapping.
    always_comb begin
        total_rnd = {1'b0, total} + (TW+1)'(ROUND_BIAS);
        norm      = DW'(total_rnd >> KSUM_LOG2);
    end
`else
    // Truncating normalise by the kernel sum.
    always_comb begin
        norm = DW'(total >> KSUM_LOG2);
    end
`endif

    // Centre pixel delay, one stage short so the output register completes the match.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < GAUSS5_LAT - 1; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            ctr_q[0] <= win_i[12*DW +: DW];
            for (int i = 1; i < GAUSS5_LAT - 1; i++) begin
                ctr_q[i] <= ctr_q[i-1];
            end
        end
    end

    // Sync delay lines, identical in both bypass modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < GAUSS5_LAT; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= '{de: de_i, hs: hs_i, vs: vs_i};
            for (int i = 1; i < GAUSS5_LAT; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // S5 output register; bypass is sampled here only, so toggling needs no flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            do_q <= '0;
        end else begin
            do_q <= bypass ? ctr_q[GAUSS5_LAT-2] : norm;
        end
    end

    assign do_o = do_q;
    assign de_o = sync_q[GAUSS5_LAT-1].de;
    assign hs_o = sync_q[GAUSS5_LAT-1].hs;
    assign vs_o = sync_q[GAUSS5_LAT-1].vs;

endmodule

// File: tb/tb_filter_gauss_5x5.sv
// Scoreboard bench for filter_gauss_5x5 against a direct 5x5 convolution model.
module tb_filter_gauss_5x5;

    localparam int unsigned DW = 12;
    localparam int unsigned WW = 25 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bypass = 1'b0;
    logic [WW-1:0] win = '0;
    logic          de_i = 1'b0;
    logic          hs_i = 1'b0;
    logic          vs_i = 1'b0;
    logic [DW-1:0] do_o;
    logic          de_o;
    logic          hs_o;
    logic          vs_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          rst;
        bit          de;
        bit          hs;
        bit          vs;
        int unsigned filt;
        int unsigned cen;
    } ent_t;

    ent_t q[$];

    filter_gauss_5x5 #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bypass (bypass),
        .win_i  (win),
        .de_i   (de_i),
        .hs_i   (hs_i),
        .vs_i   (vs_i),
        .do_o   (do_o),
        .de_o   (de_o),
        .hs_o   (hs_o),
        .vs_o   (vs_o)
    );

    always #5 clk = ~clk;

    // Reference: full 2-D convolution with the outer-product kernel, then normalise.
    function automatic int unsigned gauss(input logic [WW-1:0] w);
        int unsigned k[5] = '{1, 4, 6, 4, 1};
        int unsigned t = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                t += k[r] * k[c] * int'(w[(r*5+c)*DW +: DW]);
            end
        end
`ifdef FILTER_GAUSS_5X5_ROUND_EN
        return (t + 128) / 256;
`else
        return t / 256;
`endif
    endfunction

    function automatic logic [WW-1:0] fill(input int unsigned v);
        logic [WW-1:0] w;
        for (int i = 0; i < 25; i++) w[i*DW +: DW] = DW'(v);
        return w;
    endfunction

    function automatic logic [WW-1:0] impulse(input int unsigned idx, input int unsigned v);
        logic [WW-1:0] w = '0;
        w[idx*DW +: DW] = DW'(v);
        return w;
    endfunction

    function automatic logic [WW-1:0] rand_win();
        logic [WW-1:0] w;
        for (int i = 0; i < 25; i++) w[i*DW +: DW] = DW'($urandom_range(0, 4095));
        return w;
    endfunction

    // Drive one clock worth of inputs and record what the DUT should make of it.
    task automatic drive(input logic [WW-1:0] w, input bit d, input bit h, input bit v,
                         input bit b, input bit r);
        ent_t e;
        @(negedge clk);
        win    = w;
        de_i   = d;
        hs_i   = h;
        vs_i   = v;
        bypass = b;
        rst    = r;
        e.rst  = r;
        e.de   = d;
        e.hs   = h;
        e.vs   = v;
        e.filt = gauss(w);
        e.cen  = int'(w[12*DW +: DW]);
        q.push_back(e);
    endtask

    task automatic hold(input logic [WW-1:0] w, input bit b);
        for (int i = 0; i < 3; i++) drive(w, 1'b1, 1'b0, 1'b0, b, 1'b0);
        drive(w, 1'b0, 1'b0, 1'b0, b, 1'b0);
    endtask

    // Monitor: output after edge n reflects inputs of edge n-4, zeroed by any reset in n-4..n.
    initial begin
        ent_t        hist[$];
        ent_t        e;
        bit          byp;
        bit          zero;
        int unsigned exp_do;
        forever begin
            @(posedge clk);
            byp = bypass;
            #1;
            if (q.size() == 0) continue;
            e = q.pop_front();
            hist.push_back(e);
            if (hist.size() > 5) void'(hist.pop_front());
            zero = 1'b0;
            foreach (hist[i]) if (hist[i].rst) zero = 1'b1;
            if (hist.size() < 5 && !zero) continue;
            vectors++;
            if (zero) begin
                if ({de_o, hs_o, vs_o} !== 3'b000 || do_o !== '0) begin
                    miscompares++;
                    $display("FAIL reset: de/hs/vs=%b do=%0d, want 000 do=0",
                             {de_o, hs_o, vs_o}, do_o);
                end
            end else begin
                if ({de_o, hs_o, vs_o} !== {hist[0].de, hist[0].hs, hist[0].vs}) begin
                    miscompares++;
                    $display("FAIL sync @%0t: de/hs/vs=%b want %b", $time, {de_o, hs_o, vs_o},
                             {hist[0].de, hist[0].hs, hist[0].vs});
                end
                if (hist[0].de) begin
                    vectors++;
                    exp_do = byp ? hist[0].cen : hist[0].filt;
                    if (do_o !== DW'(exp_do)) begin
                        miscompares++;
                        $display("FAIL pixel @%0t (bypass=%0d): do=%0d want %0d",
                                 $time, byp, do_o, exp_do);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [WW-1:0] w;
        bit            b;
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        hold(fill(100), 1'b0);
        hold(impulse(12, 256), 1'b0);
        hold(impulse(0, 256), 1'b0);
        hold(impulse(6, 256), 1'b0);
        hold(impulse(0, 255), 1'b0);
        hold(impulse(0, 127), 1'b0);
        hold(fill(4095), 1'b0);
        hold(fill(0), 1'b0);
        w = rand_win();
        w[12*DW +: DW] = 12'hABC;
        hold(w, 1'b1);
        hold(w, 1'b0);

        // Streamed frames at two de cadences, bypass toggled mid-line, reset mid-line.
        for (int p = 0; p <= 2; p += 2) begin
            b = 1'b0;
            w = rand_win();
            for (int n = 0; n < 300; n++) begin
                bit d = (n % (p + 1)) == 0;
                if (d) w = rand_win();
                if (n % 41 == 40) b = ~b;
                drive(w, d, (n % 50) < 2, (n % 200) == 0, b, (n >= 150 && n < 153));
            end
        end

        for (int i = 0; i < 10; i++) drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
